// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX-stage operand forwarding from MEM/WB plus
// load-use hazard detection with a one-cycle stall FSM and a saturating
// stall counter.
// Optional feature: define FWD_STORE_DATA_EN to also forward the store
// data operand (ex_store_b) from the rs2 forwarding path.
module forward_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int DATA_W   = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [1:0]        id_alusrc0,
  input  logic [1:0]        id_alusrc1,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [DATA_W-1:0] ex_store_b_in,
  output logic [1:0]        ex_alusrc0,
  output logic [1:0]        ex_alusrc1,
  output logic [DATA_W-1:0] ex_fwd_a,
  output logic [DATA_W-1:0] ex_fwd_b,
  output logic [DATA_W-1:0] ex_store_b,
  output logic              stall,
  output logic [15:0]       stall_count
);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t r_state;
  state_t w_next_state;

  // EX slot
  logic              r_ex_valid;
  logic [REG_W-1:0]  r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  logic [REG_W-1:0]  r_ex_rs1;
  logic [REG_W-1:0]  r_ex_rs2;
  logic [1:0]        r_ex_alusrc0;
  logic [1:0]        r_ex_alusrc1;
  // MEM slot
  logic              r_mem_valid;
  logic [REG_W-1:0]  r_mem_rd;
  logic              r_mem_regwrite;
  logic              r_mem_memread;
  // WB slot (its load flag never affects forwarding, so it is not kept)
  logic              r_wb_valid;
  logic [REG_W-1:0]  r_wb_rd;
  logic              r_wb_regwrite;

  logic [15:0]       r_stall_count;

  logic w_stall;
  logic w_hazard;
  logic w_ex_src;
  logic w_mem_src;
  logic w_wb_src;
  logic w_mem_fa;
  logic w_wb_fa;
  logic w_mem_fb;
  logic w_wb_fb;
  logic w_fwd_b_act;

  // A slot can feed a consumer only when it will really write a non-zero register
  assign w_ex_src  = r_ex_valid  && r_ex_regwrite  && ((ZERO_REG == 0) || (r_ex_rd  != '0));
  assign w_mem_src = r_mem_valid && r_mem_regwrite && ((ZERO_REG == 0) || (r_mem_rd != '0));
  assign w_wb_src  = r_wb_valid  && r_wb_regwrite  && ((ZERO_REG == 0) || (r_wb_rd  != '0));

  // A load sitting in MEM has no data yet, so it is skipped and WB may serve instead
  assign w_mem_fa = w_mem_src && !r_mem_memread && (r_mem_rd == r_ex_rs1);
  assign w_wb_fa  = w_wb_src  && (r_wb_rd == r_ex_rs1);
  assign w_mem_fb = w_mem_src && !r_mem_memread && (r_mem_rd == r_ex_rs2);
  assign w_wb_fb  = w_wb_src  && (r_wb_rd == r_ex_rs2);
  assign w_fwd_b_act = w_mem_fb || w_wb_fb;

  assign w_hazard = id_valid && w_ex_src && r_ex_memread &&
                    ((id_rs1 == r_ex_rd) || (id_rs2 == r_ex_rd));

  // Operand select and forwarded value, MEM taking priority over WB
  always_comb begin
    ex_alusrc0 = r_ex_alusrc0;
    ex_alusrc1 = r_ex_alusrc1;
    ex_fwd_a   = '0;
    ex_fwd_b   = '0;
    if (w_mem_fa) begin
      ex_alusrc0 = 2'b10;
      ex_fwd_a   = mem_result;
    end else if (w_wb_fa) begin
      ex_alusrc0 = 2'b10;
      ex_fwd_a   = wb_result;
    end
    if (w_mem_fb) begin
      ex_alusrc1 = 2'b11;
      ex_fwd_b   = mem_result;
    end else if (w_wb_fb) begin
      ex_alusrc1 = 2'b11;
      ex_fwd_b   = wb_result;
    end
  end

`ifdef FWD_STORE_DATA_EN
  assign ex_store_b = w_fwd_b_act ? ex_fwd_b : ex_store_b_in;
`else
  assign ex_store_b = ex_store_b_in;
`endif

  // Stall FSM next state and stall output; flush always wins over a hazard
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hazard && !flush) begin
          w_stall      = 1'b1;
          w_next_state = S_STALL;
        end
      end
      S_STALL: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) w_next_state = S_IDLE;
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

  // Stall FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // EX slot: take the decode instruction, or a bubble on stall/flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_alusrc0  <= '0;
      r_ex_alusrc1  <= '0;
    end else if (w_stall || flush) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_alusrc0  <= '0;
      r_ex_alusrc1  <= '0;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_rd       <= id_rd;
      r_ex_regwrite <= id_regwrite;
      r_ex_memread  <= id_memread;
      r_ex_rs1      <= id_rs1;
      r_ex_rs2      <= id_rs2;
      r_ex_alusrc0  <= id_alusrc0;
      r_ex_alusrc1  <= id_alusrc1;
    end
  end

  // MEM and WB slots advance every cycle regardless of stall/flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_count <= '0;
    else if (w_stall && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed table-driven bench for forward_hazard_unit (default parameters).
// Honours FWD_STORE_DATA_EN when expecting ex_store_b.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread;
  logic [1:0]  id_alusrc0, id_alusrc1;
  logic        flush;
  logic [15:0] mem_result, wb_result, ex_store_b_in;
  logic [1:0]  ex_alusrc0, ex_alusrc1;
  logic [15:0] ex_fwd_a, ex_fwd_b, ex_store_b;
  logic        stall;
  logic [15:0] stall_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  forward_hazard_unit #(.REG_W(4), .DATA_W(16), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_alusrc0(id_alusrc0), .id_alusrc1(id_alusrc1), .flush(flush),
    .mem_result(mem_result), .wb_result(wb_result), .ex_store_b_in(ex_store_b_in),
    .ex_alusrc0(ex_alusrc0), .ex_alusrc1(ex_alusrc1),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_store_b(ex_store_b),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // flags = {valid, regwrite, memread, flush}; asel = {alusrc0, alusrc1}
  typedef struct {
    logic [3:0]  flags;
    logic [3:0]  rs1, rs2, rd;
    logic [3:0]  asel;
    logic [15:0] memr, wbr;
    logic [3:0]  e_asel;
    logic [15:0] e_fa, e_fb, e_sbm;
    logic        e_st;
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] ALU = 4'b1100;
  localparam logic [3:0] LD  = 4'b1110;
  localparam logic [3:0] ST  = 4'b1000;
  localparam logic [3:0] FL  = 4'b0001;
  localparam logic [15:0] S  = 16'h1111;

  vec_t vecs[$];

  task automatic put(input logic [3:0] flags, input logic [3:0] rs1, input logic [3:0] rs2,
                     input logic [3:0] rd, input logic [3:0] asel, input logic [15:0] memr,
                     input logic [15:0] wbr, input logic [3:0] e_asel, input logic [15:0] e_fa,
                     input logic [15:0] e_fb, input logic [15:0] e_sbm, input logic e_st,
                     input logic [15:0] e_cnt);
    vec_t v;
    v.flags = flags; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.asel = asel;
    v.memr = memr; v.wbr = wbr; v.e_asel = e_asel; v.e_fa = e_fa; v.e_fb = e_fb;
    v.e_sbm = e_sbm; v.e_st = e_st; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] flags, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [3:0] asel);
    id_valid    = flags[3];
    id_regwrite = flags[2];
    id_memread  = flags[1];
    flush       = flags[0];
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alusrc0 = asel[3:2]; id_alusrc1 = asel[1:0];
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_sb;
    reset = 1'b1;
    drive(NOP, 0, 0, 0, 0);
    mem_result = 16'h0; wb_result = 16'h0; ex_store_b_in = S;

    // ADD r3 ; ADD r4,r3,r5 -> MEM forward on rs1
    put(ALU, 1, 2, 3, 4'b0000, 16'h1234, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    put(ALU, 3, 5, 4, 4'b0101, 16'h1234, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'h1234, 16'h0BAD, 4'b1001, 16'h1234, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'h1234, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'h1234, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    // r3 in MEM and WB, consumer rs2=r3 -> MEM wins
    put(ALU, 1, 1, 3, 4'b0000, 16'hAAAA, 16'h5555, 4'b0000, 0, 0, S, 0, 0);
    put(ALU, 1, 1, 3, 4'b0000, 16'hAAAA, 16'h5555, 4'b0000, 0, 0, S, 0, 0);
    put(ST,  6, 3, 0, 4'b0000, 16'hAAAA, 16'h5555, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hAAAA, 16'h5555, 4'b0011, 0, 16'hAAAA, 16'hAAAA, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hAAAA, 16'h5555, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hAAAA, 16'h5555, 4'b0000, 0, 0, S, 0, 0);
    // ADD r7 ; SW rs2=r7 -> store data forward
    put(ALU, 1, 1, 7, 4'b0000, 16'h00FF, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    put(ST,  2, 7, 0, 4'b0001, 16'h00FF, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'h00FF, 16'h0BAD, 4'b0011, 0, 16'h00FF, 16'h00FF, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'h00FF, 16'h0BAD, 4'b0000, 0, 0, S, 0, 0);
    // ADD r0 ; use r0 -> no forward, selects pass through
    put(ALU, 1, 1, 0, 4'b0000, 16'hDEAD, 16'hBEEF, 4'b0000, 0, 0, S, 0, 0);
    put(ALU, 0, 0, 5, 4'b0110, 16'hDEAD, 16'hBEEF, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hDEAD, 16'hBEEF, 4'b0110, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hDEAD, 16'hBEEF, 4'b0000, 0, 0, S, 0, 0);
    put(NOP, 0, 0, 0, 4'b0000, 16'hDEAD, 16'hBEEF, 4'b0000, 0, 0, S, 0, 0);
    // LW r2 ; ADD r6,r2,r1 -> one stall, then WB forward
    put(LD,  1, 0, 2, 4'b0001, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 0);
    put(ALU, 2, 1, 6, 4'b0000, 16'h3333, 16'h7777, 4'b0001, 0, 0, S, 1, 0);
    put(ALU, 2, 1, 6, 4'b0000, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);
    put(NOP, 0, 0, 0, 4'b0000, 16'h3333, 16'h7777, 4'b1000, 16'h7777, 0, S, 0, 1);
    put(NOP, 0, 0, 0, 4'b0000, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);
    // LW r2 ; flush coinciding with the load-use -> no stall, EX bubble
    put(LD,  1, 0, 2, 4'b0001, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);
    put(ALU | FL, 2, 1, 6, 4'b0100, 16'h3333, 16'h7777, 4'b0001, 0, 0, S, 0, 1);
    put(NOP, 0, 0, 0, 4'b0000, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);
    put(NOP, 0, 0, 0, 4'b0000, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);
    put(NOP, 0, 0, 0, 4'b0000, 16'h3333, 16'h7777, 4'b0000, 0, 0, S, 0, 1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_asel", -1, {12'h0, ex_alusrc0, ex_alusrc1}, 16'h0);
    chk("rst_fwd_a", -1, ex_fwd_a, 16'h0);
    chk("rst_fwd_b", -1, ex_fwd_b, 16'h0);
    chk("rst_stall", -1, {15'h0, stall}, 16'h0);
    chk("rst_count", -1, stall_count, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flags, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].asel);
      mem_result = vecs[i].memr;
      wb_result  = vecs[i].wbr;
      #2;
`ifdef FWD_STORE_DATA_EN
      exp_sb = vecs[i].e_sbm;
`else
      exp_sb = S;
`endif
      chk("asel",    i, {12'h0, ex_alusrc0, ex_alusrc1}, {12'h0, vecs[i].e_asel});
      chk("fwd_a",   i, ex_fwd_a, vecs[i].e_fa);
      chk("fwd_b",   i, ex_fwd_b, vecs[i].e_fb);
      chk("store_b", i, ex_store_b, exp_sb);
      chk("stall",   i, {15'h0, stall}, {15'h0, vecs[i].e_st});
      chk("count",   i, stall_count, vecs[i].e_cnt);
    end

    // Reset asserted while a load-use stall is pending
    @(negedge clk);
    drive(LD, 1, 0, 2, 4'b0001);
    @(negedge clk);
    drive(ALU, 2, 1, 6, 4'b0100);
    #2;
    chk("mid_stall", 0, {15'h0, stall}, 16'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 0, {15'h0, stall}, 16'h0);
    chk("mid_rst_count", 0, stall_count, 16'h0);
    chk("mid_rst_asel", 0, {12'h0, ex_alusrc0, ex_alusrc1}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("post_rst_stall", 0, {15'h0, stall}, 16'h0);
    @(negedge clk);
    drive(NOP, 0, 0, 0, 0);
    #2;
    chk("post_rst_asel", 0, {12'h0, ex_alusrc0, ex_alusrc1}, 16'h4);
    chk("post_rst_fwd_a", 0, ex_fwd_a, 16'h0);
    chk("post_rst_count", 0, stall_count, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
